i2s_clkws_cfg_seq: RTL and testbench

- Sequencer that owns every control input of the I2S clock/WS generator: enables, clock source selects, dividers and word framing.
- Applies a new configuration glitch-safely: disable, drain, apply, settle, re-enable.
- The generator's clock muxes and WS counters are never reconfigured while running.
- Sits between the uDMA I2S register file (shadow config + request strobe) and the clock/WS generator, in the peripheral clock domain.

---
 rtl/i2s_clkws_cfg_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2s_clkws_cfg_seq.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clkws_cfg_seq.sv
// Glitch-safe configuration sequencer for the I2S clock/WS generator: disable, drain, apply,
// settle, re-enable. Define I2S_CFG_SEQ_FASTPATH_EN to skip disable/drain when already idle.
module i2s_clkws_cfg_seq #(
    parameter int unsigned SETTLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,

    input  logic                cfg_req_i,
    input  logic [SETTLE_W-1:0] cfg_settle_i,
    input  logic                cfg_master_en_i,
    input  logic                cfg_slave_en_i,
    input  logic                cfg_pdm_en_i,
    input  logic                cfg_sel_master_num_i,
    input  logic                cfg_sel_master_ext_i,
    input  logic                cfg_sel_slave_num_i,
    input  logic                cfg_sel_slave_ext_i,
    input  logic [15:0]         cfg_div_0_i,
    input  logic [15:0]         cfg_div_1_i,
    input  logic [4:0]          cfg_word_size_0_i,
    input  logic [4:0]          cfg_word_size_1_i,
    input  logic [2:0]          cfg_word_num_0_i,
    input  logic [2:0]          cfg_word_num_1_i,

    output logic                master_en_o,
    output logic                slave_en_o,
    output logic                pdm_en_o,
    output logic                sel_master_num_o,
    output logic                sel_master_ext_o,
    output logic                sel_slave_num_o,
    output logic                sel_slave_ext_o,
    output logic [15:0]         div_0_o,
    output logic [15:0]         div_1_o,
    output logic [4:0]          word_size_0_o,
    output logic [4:0]          word_size_1_o,
    output logic [2:0]          word_num_0_o,
    output logic [2:0]          word_num_1_o,

    output logic                busy_o,
    output logic                done_o,
    output logic                pend_o
);

    typedef struct packed {
        logic        master_en;
        logic        slave_en;
        logic        pdm_en;
        logic        sel_master_num;
        logic        sel_master_ext;
        logic        sel_slave_num;
        logic        sel_slave_ext;
        logic [15:0] div_0;
        logic [15:0] div_1;
        logic [4:0]  word_size_0;
        logic [4:0]  word_size_1;
        logic [2:0]  word_num_0;
        logic [2:0]  word_num_1;
    } gen_cfg_t;

    typedef struct packed {
        gen_cfg_t            gen;
        logic [SETTLE_W-1:0] settle;
    } seq_cfg_t;

    typedef enum logic [2:0] {
        StIdle,
        StDisable,
        StDrain,
        StApply,
        StSettle,
        StEnable
    } state_e;

    // Pads default to inputs so nothing is driven externally before the first configuration.
    localparam gen_cfg_t GenRst = '{
        master_en:      1'b0,
        slave_en:       1'b0,
        pdm_en:         1'b0,
        sel_master_num: 1'b0,
        sel_master_ext: 1'b1,
        sel_slave_num:  1'b0,
        sel_slave_ext:  1'b1,
        div_0:          16'h0000,
        div_1:          16'h0000,
        word_size_0:    5'd0,
        word_size_1:    5'd0,
        word_num_0:     3'd0,
        word_num_1:     3'd0
    };

    localparam logic [SETTLE_W-1:0] CntOne = SETTLE_W'(1);

    state_e              state_q;
    gen_cfg_t            gen_q;
    seq_cfg_t            shadow_q;
    seq_cfg_t            act_q;
    logic [SETTLE_W-1:0] cnt_q;
    logic                pend_q;
    logic                busy_q;
    logic                done_q;

    seq_cfg_t            req_cfg;
    seq_cfg_t            start_cfg;
    logic                fast_path;

    always_comb begin
        req_cfg.gen.master_en      = cfg_master_en_i;
        req_cfg.gen.slave_en       = cfg_slave_en_i;
        req_cfg.gen.pdm_en         = cfg_pdm_en_i;
        req_cfg.gen.sel_master_num = cfg_sel_master_num_i;
        req_cfg.gen.sel_master_ext = cfg_sel_master_ext_i;
        req_cfg.gen.sel_slave_num  = cfg_sel_slave_num_i;
        req_cfg.gen.sel_slave_ext  = cfg_sel_slave_ext_i;
        req_cfg.gen.div_0          = cfg_div_0_i;
        req_cfg.gen.div_1          = cfg_div_1_i;
        req_cfg.gen.word_size_0    = cfg_word_size_0_i;
        req_cfg.gen.word_size_1    = cfg_word_size_1_i;
        req_cfg.gen.word_num_0     = cfg_word_num_0_i;
        req_cfg.gen.word_num_1     = cfg_word_num_1_i;
        req_cfg.settle             = cfg_settle_i;
    end

    // A request in the same IDLE cycle as a pending one is newer, so it wins.
    assign start_cfg = cfg_req_i ? req_cfg : shadow_q;

`ifdef I2S_CFG_SEQ_FASTPATH_EN
    logic all_en_off;
    assign all_en_off = ~(gen_q.master_en | gen_q.slave_en | gen_q.pdm_en);
    assign fast_path  = all_en_off;
`else
    assign fast_path  = 1'b0;
`endif

    function automatic gen_cfg_t with_enables_off(gen_cfg_t c);
        gen_cfg_t r;
        r           = c;
        r.master_en = 1'b0;
        r.slave_en  = 1'b0;
        r.pdm_en    = 1'b0;
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            gen_q    <= GenRst;
            shadow_q <= '0;
            act_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_req_i) begin
                shadow_q <= req_cfg;
            end
            if (cfg_req_i && (state_q != StIdle)) begin
                pend_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_req_i || pend_q) begin
                        act_q  <= start_cfg;
                        cnt_q  <= start_cfg.settle;
                        pend_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (fast_path) begin
                            state_q <= StApply;
                            gen_q   <= with_enables_off(start_cfg.gen);
                        end else begin
                            state_q         <= StDisable;
                            gen_q.master_en <= 1'b0;
                            gen_q.slave_en  <= 1'b0;
                            gen_q.pdm_en    <= 1'b0;
                        end
                    end
                end

                StDisable: begin
                    state_q <= StDrain;
                end

                StDrain: begin
                    if (cnt_q == '0) begin
                        state_q <= StApply;
                        gen_q   <= with_enables_off(act_q.gen);
                        cnt_q   <= act_q.settle;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StApply: begin
                    state_q <= StSettle;
                end

                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q         <= StEnable;
                        gen_q.master_en <= act_q.gen.master_en;
                        gen_q.slave_en  <= act_q.gen.slave_en;
                        gen_q.pdm_en    <= act_q.gen.pdm_en;
                        done_q          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StEnable: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign master_en_o      = gen_q.master_en;
    assign slave_en_o       = gen_q.slave_en;
    assign pdm_en_o         = gen_q.pdm_en;
    assign sel_master_num_o = gen_q.sel_master_num;
    assign sel_master_ext_o = gen_q.sel_master_ext;
    assign sel_slave_num_o  = gen_q.sel_slave_num;
    assign sel_slave_ext_o  = gen_q.sel_slave_ext;
    assign div_0_o          = gen_q.div_0;
    assign div_1_o          = gen_q.div_1;
    assign word_size_0_o    = gen_q.word_size_0;
    assign word_size_1_o    = gen_q.word_size_1;
    assign word_num_0_o     = gen_q.word_num_0;
    assign word_num_1_o     = gen_q.word_num_1;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pend_o           = pend_q;

endmodule

// File: tb/tb_i2s_clkws_cfg_seq.sv
// Bench for i2s_clkws_cfg_seq: cycle-accurate expectations derived from each sequence's start
// cycle and settle length, compared every cycle against the DUT.
module tb_i2s_clkws_cfg_seq;

    typedef struct packed {
        logic        master_en;
        logic        slave_en;
        logic        pdm_en;
        logic        smn;
        logic        sme;
        logic        ssn;
        logic        sse;
        logic [15:0] div0;
        logic [15:0] div1;
        logic [4:0]  ws0;
        logic [4:0]  ws1;
        logic [2:0]  wn0;
        logic [2:0]  wn1;
    } fld_t;

    typedef struct packed {
        fld_t        f;
        logic [15:0] s;
    } cfg_t;

    typedef struct packed {
        fld_t f;
        logic busy;
        logic done;
        logic pend;
    } obs_t;

`ifdef I2S_CFG_SEQ_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_req = 1'b0;
    cfg_t        drv = '0;

    logic        master_en_o, slave_en_o, pdm_en_o;
    logic        sel_master_num_o, sel_master_ext_o, sel_slave_num_o, sel_slave_ext_o;
    logic [15:0] div_0_o, div_1_o;
    logic [4:0]  word_size_0_o, word_size_1_o;
    logic [2:0]  word_num_0_o, word_num_1_o;
    logic        busy_o, done_o, pend_o;

    i2s_clkws_cfg_seq #(.SETTLE_W(16)) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .cfg_req_i           (cfg_req),
        .cfg_settle_i        (drv.s),
        .cfg_master_en_i     (drv.f.master_en),
        .cfg_slave_en_i      (drv.f.slave_en),
        .cfg_pdm_en_i        (drv.f.pdm_en),
        .cfg_sel_master_num_i(drv.f.smn),
        .cfg_sel_master_ext_i(drv.f.sme),
        .cfg_sel_slave_num_i (drv.f.ssn),
        .cfg_sel_slave_ext_i (drv.f.sse),
        .cfg_div_0_i         (drv.f.div0),
        .cfg_div_1_i         (drv.f.div1),
        .cfg_word_size_0_i   (drv.f.ws0),
        .cfg_word_size_1_i   (drv.f.ws1),
        .cfg_word_num_0_i    (drv.f.wn0),
        .cfg_word_num_1_i    (drv.f.wn1),
        .master_en_o         (master_en_o),
        .slave_en_o          (slave_en_o),
        .pdm_en_o            (pdm_en_o),
        .sel_master_num_o    (sel_master_num_o),
        .sel_master_ext_o    (sel_master_ext_o),
        .sel_slave_num_o     (sel_slave_num_o),
        .sel_slave_ext_o     (sel_slave_ext_o),
        .div_0_o             (div_0_o),
        .div_1_o             (div_1_o),
        .word_size_0_o       (word_size_0_o),
        .word_size_1_o       (word_size_1_o),
        .word_num_0_o        (word_num_0_o),
        .word_num_1_o        (word_num_1_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .pend_o              (pend_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: one sequence is fully described by its start cycle, path and S.
    fld_t m_out;
    logic m_busy, m_done, m_pend;
    cfg_t m_shadow, m_cur;
    bit   m_in_seq;
    int   cyc, m_t0, m_apply, m_enable, m_idle;

    function automatic obs_t rst_obs();
        obs_t o;
        o       = '0;
        o.f.sme = 1'b1;
        o.f.sse = 1'b1;
        return o;
    endfunction

    function automatic void model_reset();
        obs_t r;
        r        = rst_obs();
        m_out    = r.f;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_pend   = 1'b0;
        m_shadow = '0;
        m_cur    = '0;
        m_in_seq = 1'b0;
        cyc      = 0;
        m_t0     = 0;
        m_apply  = 0;
        m_enable = 0;
        m_idle   = 0;
    endfunction

    function automatic void model_update(logic req, cfg_t c);
        int  p;
        int  s;
        bit  fast;
        p      = cyc;
        cyc    = cyc + 1;
        m_done = 1'b0;
        if (m_in_seq && p < m_idle) begin
            if (req) begin
                m_shadow = c;
                m_pend   = 1'b1;
            end
        end else begin
            m_in_seq = 1'b0;
            if (req || m_pend) begin
                m_cur = req ? c : m_shadow;
                if (req) m_shadow = c;
                m_pend   = 1'b0;
                s        = int'(m_cur.s);
                fast     = FAST && !(m_out.master_en || m_out.slave_en || m_out.pdm_en);
                m_t0     = cyc;
                m_in_seq = 1'b1;
                if (fast) begin
                    m_apply  = cyc;
                    m_enable = cyc + 2 + s;
                    m_idle   = cyc + 3 + s;
                end else begin
                    m_apply  = cyc + 2 + s;
                    m_enable = cyc + 4 + 2 * s;
                    m_idle   = cyc + 5 + 2 * s;
                end
            end
        end
        if (m_in_seq) begin
            if (cyc == m_t0 || cyc == m_apply) begin
                if (cyc == m_apply) m_out = m_cur.f;
                m_out.master_en = 1'b0;
                m_out.slave_en  = 1'b0;
                m_out.pdm_en    = 1'b0;
            end
            if (cyc == m_enable) begin
                m_out.master_en = m_cur.f.master_en;
                m_out.slave_en  = m_cur.f.slave_en;
                m_out.pdm_en    = m_cur.f.pdm_en;
                m_done          = 1'b1;
            end
            m_busy = (cyc < m_idle);
        end else begin
            m_busy = 1'b0;
        end
    endfunction

    function automatic obs_t exp_obs();
        obs_t o;
        o.f    = m_out;
        o.busy = m_busy;
        o.done = m_done;
        o.pend = m_pend;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.f.master_en = master_en_o;
        o.f.slave_en  = slave_en_o;
        o.f.pdm_en    = pdm_en_o;
        o.f.smn       = sel_master_num_o;
        o.f.sme       = sel_master_ext_o;
        o.f.ssn       = sel_slave_num_o;
        o.f.sse       = sel_slave_ext_o;
        o.f.div0      = div_0_o;
        o.f.div1      = div_1_o;
        o.f.ws0       = word_size_0_o;
        o.f.ws1       = word_size_1_o;
        o.f.wn0       = word_num_0_o;
        o.f.wn1       = word_num_1_o;
        o.busy        = busy_o;
        o.done        = done_o;
        o.pend        = pend_o;
        return o;
    endfunction

    function automatic cfg_t rand_cfg(int unsigned max_s);
        cfg_t c;
        c.f.master_en = 1'($urandom);
        c.f.slave_en  = 1'($urandom);
        c.f.pdm_en    = 1'($urandom);
        c.f.smn       = 1'($urandom);
        c.f.sme       = 1'($urandom);
        c.f.ssn       = 1'($urandom);
        c.f.sse       = 1'($urandom);
        c.f.div0      = 16'($urandom);
        c.f.div1      = 16'($urandom);
        c.f.ws0       = 5'($urandom);
        c.f.ws1       = 5'($urandom);
        c.f.wn0       = 3'($urandom);
        c.f.wn1       = 3'($urandom);
        c.s           = 16'($urandom_range(max_s, 0));
        return c;
    endfunction

    // Advance one clock with the currently driven inputs; req is a one-cycle strobe.
    task automatic step();
        logic r;
        cfg_t c;
        r = cfg_req;
        c = drv;
        @(posedge clk_i);
        #1;
        model_update(r, c);
        cfg_req = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        got = dut_obs();
        n_run++;
        if (got !== rst_obs()) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", got, rst_obs());
        end
        rstn_i = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, got, exp_obs());
            end
        end
    endtask

    task automatic test_first_config();
        obs_t got;
        int   apply_cyc;
        int   done_cyc;
        apply_cyc          = FAST ? 1 : 6;
        done_cyc           = FAST ? 6 : 11;
        drv                = '0;
        drv.f.sse          = 1'b1;
        drv.f.master_en    = 1'b1;
        drv.f.div0         = 16'h0004;
        drv.s              = 16'd3;
        cfg_req            = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL first_cfg cyc %0d: got %h want %h", k, got, exp_obs());
            end
            if (k == apply_cyc) begin
                n_run++;
                if (div_0_o !== 16'h0004 || master_en_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_cfg_apply: div_0 %h en %b want 0004 0", div_0_o,
                             master_en_o);
                end
            end
            if (k == done_cyc) begin
                n_run++;
                if (done_o !== 1'b1 || master_en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_cfg_done: done %b en %b want 1 1", done_o, master_en_o);
                end
            end
        end
    endtask

    task automatic test_switch_select();
        obs_t got;
        drv.f.smn  = 1'b1;
        drv.f.div1 = 16'h0010;
        drv.s      = 16'd0;
        cfg_req    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL switch_sel cyc %0d: got %h want %h", k, got, exp_obs());
            end
            n_run++;
            if ((k <= 4 && master_en_o !== 1'b0) || (k == 5 && master_en_o !== 1'b1) ||
                (k == 2 && sel_master_num_o !== 1'b0) ||
                (k == 3 && (sel_master_num_o !== 1'b1 || div_1_o !== 16'h0010))) begin
                n_fail++;
                $display("FAIL switch_sel_timing cyc %0d: en %b sel %b div1 %h", k, master_en_o,
                         sel_master_num_o, div_1_o);
            end
        end
    endtask

    task automatic test_pending();
        obs_t got;
        bit   seen7;
        seen7      = 1'b0;
        drv        = rand_cfg(4);
        drv.f.div0 = 16'h0003;
        cfg_req    = 1'b1;
        step();
        step();
        drv.f.div0 = 16'h0007;
        cfg_req    = 1'b1;
        step();
        n_run++;
        if (pend_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_flag: pend %b want 1", pend_o);
        end
        drv        = rand_cfg(4);
        drv.f.div0 = 16'h0009;
        cfg_req    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (div_0_o === 16'h0007) seen7 = 1'b1;
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL pending cyc %0d: got %h want %h", cyc, got, exp_obs());
            end
        end
        n_run++;
        if (seen7 || div_0_o !== 16'h0009 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_last_wins: seen7 %b div_0 %h busy %b want 0 0009 0", seen7,
                     div_0_o, busy_o);
        end
    endtask

    task automatic test_req_in_enable();
        obs_t got;
        int   dones;
        dones   = 0;
        drv     = rand_cfg(3);
        cfg_req = 1'b1;
        step();
        for (int i = 0; i < 50 && cyc < m_enable; i++) step();
        n_run++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_cycle_done: done %b want 1", done_o);
        end
        drv     = rand_cfg(3);
        cfg_req = 1'b1;
        step();
        n_run++;
        if (busy_o !== 1'b0 || pend_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_req_idle: busy %b pend %b done %b want 0 1 0", busy_o, pend_o,
                     done_o);
        end
        step();
        n_run++;
        if (busy_o !== 1'b1 || pend_o !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_req_restart: busy %b pend %b want 1 0", busy_o, pend_o);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            if (done_o === 1'b1) dones++;
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL enable_req cyc %0d: got %h want %h", cyc, got, exp_obs());
            end
        end
        n_run++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL enable_req_not_lost: done pulses %0d want 1", dones);
        end
    endtask

    task automatic test_random();
        obs_t got;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7, 0) == 0) begin
                drv     = rand_cfg(5);
                cfg_req = 1'b1;
            end
            step();
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, got, exp_obs());
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got;
        int   dones;
        dones = 0;
        for (int i = 0; i < 100 && (m_busy || m_pend); i++) step();
        drv       = rand_cfg(0);
        drv.s     = 16'd4;
        cfg_req   = 1'b1;
        step();
        drv       = rand_cfg(2);
        cfg_req   = 1'b1;
        step();
        for (int i = 0; i < 50 && cyc < m_apply + 2; i++) step();
        #2;
        rstn_i = 1'b0;
        #1;
        got = dut_obs();
        n_run++;
        if (got !== rst_obs()) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want %h", got, rst_obs());
        end
        model_reset();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_o === 1'b1) dones++;
            got = dut_obs();
            n_run++;
            if (got !== exp_obs()) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %h want %h", cyc, got, exp_obs());
            end
        end
        n_run++;
        if (dones != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: done pulses %0d busy %b want 0 0", dones, busy_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_config();
        test_switch_select();
        test_pending();
        test_req_in_enable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
